// File: rtl/mips_defs.sv
// Shared MIPS P5 fetch-stage definitions: PC redirect codes, opcodes and reset constants.
package mips_defs;

   localparam logic [1:0]  PCOP_PC4     = 2'b00;
   localparam logic [1:0]  PCOP_NPC     = 2'b01;
   localparam logic [1:0]  PCOP_JR      = 2'b10;
   localparam logic [5:0]  OP_BEQ       = 6'b000100;
   localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
   localparam logic [31:0] NOP          = 32'h0000_0000;

endpackage

// File: rtl/npc_calc.sv
// Next-PC selection: beq / j / jal targets from the IF/ID instruction, jr target, or sequential PC+4.
// Purely combinational; pcop 2'b11 falls back to PC+4.
module npc_calc
   import mips_defs::*;
(
   input  logic [31:0] instr_D,
   input  logic [31:0] pc4_D,
   input  logic [1:0]  pcop,
   input  logic [31:0] jr_target,
   input  logic [31:0] pc_F,
   output logic [31:0] next_pc
);

   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] npc;

   assign br_tgt = pc4_D + {{14{instr_D[15]}}, instr_D[15:0], 2'b00};
   assign j_tgt  = {pc4_D[31:28], instr_D[25:0], 2'b00};
   assign npc    = (instr_D[31:26] == OP_BEQ) ? br_tgt : j_tgt;

   always_comb begin
      next_pc = pc_F + 32'd4;
      case (pcop)
         PCOP_NPC: next_pc = npc;
         PCOP_JR:  next_pc = jr_target;
         default:  next_pc = pc_F + 32'd4;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// MIPS P5 instruction fetch: PC register, IM window check, IF/ID register and sticky pc_err.
// Optional FETCH_BRANCH_FLUSH_EN squashes the delay slot on redirect.
module fetch_unit
   import mips_defs::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEF,
   parameter int          IM_AW    = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stall,
   input  logic [1:0]       pcop,
   input  logic [31:0]      jr_target,
   output logic [IM_AW-1:0] imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      pc_F,
   output logic [31:0]      instr_D,
   output logic [31:0]      pc_D,
   output logic [31:0]      pc4_D,
   output logic             pc_err
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcd_q, pcd_d;
   logic        err_q, err_d;
   logic [31:0] next_pc;
   logic [29:0] offs_w;
   logic        fetch_bad;
   logic [31:0] fetched;
   logic [31:0] if_word;

   // PC_RESET is the word-aligned IM base, so the word offset can be taken before subtracting.
   assign offs_w    = pc_q[31:2] - PC_RESET[31:2];
   assign imem_addr = offs_w[IM_AW-1:0];
   assign fetch_bad = (pc_q[1:0] != 2'b00) || (|offs_w[29:IM_AW]);
   assign fetched   = fetch_bad ? NOP : imem_rdata;

`ifdef FETCH_BRANCH_FLUSH_EN
   assign if_word = ((pcop == PCOP_NPC) || (pcop == PCOP_JR)) ? NOP : fetched;
`else
   assign if_word = fetched;
`endif

   npc_calc u_npc (
      .instr_D   (instr_q),
      .pc4_D     (pc4_D),
      .pcop      (pcop),
      .jr_target (jr_target),
      .pc_F      (pc_q),
      .next_pc   (next_pc)
   );

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pcd_d   = pcd_q;
      err_d   = err_q;
      if (!stall) begin
         pc_d    = next_pc;
         instr_d = if_word;
         pcd_d   = pc_q;
         err_d   = err_q | fetch_bad;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q    <= PC_RESET;
         instr_q <= NOP;
         pcd_q   <= PC_RESET;
         err_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pcd_q   <= pcd_d;
         err_q   <= err_d;
      end
   end

   assign pc_F    = pc_q;
   assign instr_D = instr_q;
   assign pc_D    = pcd_q;
   assign pc4_D   = pcd_q + 32'd4;
   assign pc_err  = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit: each driven cycle queues the expected post-edge state.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall = 1'b0;
   logic [1:0]  pcop = 2'b00;
   logic [31:0] jr_target = 32'h0;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc_F, instr_D, pc_D, pc4_D;
   logic        pc_err;

   logic [31:0] mem [1024];
   assign imem_rdata = mem[imem_addr];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic [31:0] pcd;
      logic        err;
      logic [9:0]  ia;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   fetch_unit #(.PC_RESET(32'h0000_3000), .IM_AW(10)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .stall      (stall),
      .pcop       (pcop),
      .jr_target  (jr_target),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .pc_F       (pc_F),
      .instr_D    (instr_D),
      .pc_D       (pc_D),
      .pc4_D      (pc4_D),
      .pc_err     (pc_err)
   );

   always #5 clk = ~clk;

   // Delay-slot word on a redirect edge; squashed when the flush build is selected.
   function automatic logic [31:0] slot(input logic [31:0] w);
`ifdef FETCH_BRANCH_FLUSH_EN
      return 32'h0;
`else
      return w;
`endif
   endfunction

   task automatic drive(input logic rn, input logic st, input logic [1:0] op, input logic [31:0] jt,
                        input logic [31:0] e_pc, input logic [31:0] e_ins, input logic [31:0] e_pcd,
                        input logic e_err, input logic [9:0] e_ia);
      exp_t e;
      @(negedge clk);
      reset_n   = rn;
      stall     = st;
      pcop      = op;
      jr_target = jt;
      e.pc = e_pc; e.ins = e_ins; e.pcd = e_pcd; e.err = e_err; e.ia = e_ia;
      exp_q.push_back(e);
   endtask

   task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s got %h want %h", nm, got, want);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk32("pc_F", pc_F, e.pc);
         chk32("instr_D", instr_D, e.ins);
         chk32("pc_D", pc_D, e.pcd);
         chk32("pc4_D", pc4_D, e.pcd + 32'd4);
         chk32("pc_err", {31'b0, pc_err}, {31'b0, e.err});
         chk32("imem_addr", {22'b0, imem_addr}, {22'b0, e.ia});
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h2400_0000 | i;
      mem[4]    = 32'h1000_FFFF;   // beq back to itself (target 0x3010)
      mem[6]    = 32'h0800_0C10;   // j 0x3040
      mem[10'h40] = 32'h0800_0C10; // j 0x3040, used under stall

      // reset held two edges
      drive(0, 0, 2'b00, 0, 32'h3000, 32'h0, 32'h3000, 0, 10'd0);
      drive(0, 1, 2'b01, 0, 32'h3000, 32'h0, 32'h3000, 0, 10'd0);
      // sequential fetch; pcop 11 behaves as 00
      drive(1, 0, 2'b00, 0, 32'h3004, 32'h2400_0000, 32'h3000, 0, 10'd1);
      drive(1, 0, 2'b00, 0, 32'h3008, 32'h2400_0001, 32'h3004, 0, 10'd2);
      drive(1, 0, 2'b11, 0, 32'h300C, 32'h2400_0002, 32'h3008, 0, 10'd3);
      drive(1, 0, 2'b00, 0, 32'h3010, 32'h2400_0003, 32'h300C, 0, 10'd4);
      drive(1, 0, 2'b00, 0, 32'h3014, 32'h1000_FFFF, 32'h3010, 0, 10'd5);
      // beq taken: target 0x3010, delay slot 0x3014 enters IF/ID
      drive(1, 0, 2'b01, 0, 32'h3010, slot(32'h2400_0005), 32'h3014, 0, 10'd4);
      drive(1, 0, 2'b00, 0, 32'h3014, 32'h1000_FFFF, 32'h3010, 0, 10'd5);
      drive(1, 0, 2'b00, 0, 32'h3018, 32'h2400_0005, 32'h3014, 0, 10'd6);
      drive(1, 0, 2'b00, 0, 32'h301C, 32'h0800_0C10, 32'h3018, 0, 10'd7);
      // j 0x3040
      drive(1, 0, 2'b01, 0, 32'h3040, slot(32'h2400_0007), 32'h301C, 0, 10'h10);
      drive(1, 0, 2'b00, 0, 32'h3044, 32'h2400_0010, 32'h3040, 0, 10'h11);
      // jr 0x3100
      drive(1, 0, 2'b10, 32'h3100, 32'h3100, slot(32'h2400_0011), 32'h3044, 0, 10'h40);
      drive(1, 0, 2'b00, 0, 32'h3104, 32'h0800_0C10, 32'h3100, 0, 10'h41);
      // stall over redirect: nothing moves, no flush
      for (int i = 0; i < 3; i++)
         drive(1, 1, 2'b01, 0, 32'h3104, 32'h0800_0C10, 32'h3100, 0, 10'h41);
      drive(1, 0, 2'b01, 0, 32'h3040, slot(32'h2400_0041), 32'h3104, 0, 10'h10);
      drive(1, 0, 2'b00, 0, 32'h3044, 32'h2400_0010, 32'h3040, 0, 10'h11);
      // misaligned jr
      drive(1, 0, 2'b10, 32'h3002, 32'h3002, slot(32'h2400_0011), 32'h3044, 0, 10'd0);
      drive(1, 0, 2'b00, 0, 32'h3006, 32'h0, 32'h3002, 1, 10'd1);
      drive(1, 0, 2'b10, 32'h3000, 32'h3000, 32'h0, 32'h3006, 1, 10'd0);
      drive(1, 0, 2'b00, 0, 32'h3004, 32'h2400_0000, 32'h3000, 1, 10'd1);
      // reset clears the sticky error
      drive(0, 0, 2'b00, 0, 32'h3000, 32'h0, 32'h3000, 0, 10'd0);
      // last word in window is fine, first word past it errors
      drive(1, 0, 2'b10, 32'h3FFC, 32'h3FFC, slot(32'h2400_0000), 32'h3000, 0, 10'h3FF);
      drive(1, 0, 2'b00, 0, 32'h4000, 32'h2400_03FF, 32'h3FFC, 0, 10'd0);
      drive(1, 0, 2'b00, 0, 32'h4004, 32'h0, 32'h4000, 1, 10'd1);
      drive(1, 0, 2'b00, 0, 32'h4008, 32'h0, 32'h4004, 1, 10'd2);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain left %0d want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
